// File: rtl/pulse_shaper_pkg.sv
// Shared types and constants for the GPIO pulse shaper.
// Imported by the shaper top and its saturating counters.
package pulse_shaper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [15:0] WIDTH_DEF = 16'd5;
  localparam logic [15:0] DEAD_DEF  = 16'd0;

  // Cycle-counter load value; a zero length behaves as one cycle.
  function automatic logic [15:0] load_val(
    input logic [15:0] v
  );
    return (v == 16'd0) ? 16'd0 : 16'(v - 16'd1);
  endfunction

endpackage

// File: rtl/pulse_shaper_sat_counter.sv
// Saturating up-counter with clear taking priority over increment.
// Used for accept, drop and per-window accept counts.
module sat_counter
  import pulse_shaper_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic full;

  assign full = &cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_shaper.sv
// Shapes single-cycle triggers into a programmable-width pulse plus
// dead time, with accept/drop statistics and a windowed rate.
module pulse_shaper
  import pulse_shaper_pkg::*;
#(
  parameter int          P_CNT_BITS    = 32,
  parameter int          P_RATE_WINDOW = 50_000_000,
  parameter logic [15:0] P_WIDTH_RST   = WIDTH_DEF,
  parameter logic [15:0] P_DEAD_RST    = DEAD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trig,
  input  logic                  enable,
  input  logic [15:0]           width,
  input  logic                  width_wr,
  input  logic [15:0]           deadtime,
  input  logic                  deadtime_wr,
  input  logic                  cnt_clr,
  output logic                  pulse_o,
  output logic                  busy,
  output logic [P_CNT_BITS-1:0] n_accept,
  output logic [P_CNT_BITS-1:0] n_drop,
  output logic [P_CNT_BITS-1:0] rate,
  output logic                  rate_valid
);

  localparam int WIN_W =
    (P_RATE_WINDOW > 1) ? $clog2(P_RATE_WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST =
    WIN_W'(P_RATE_WINDOW - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] tmr_q;
  logic [15:0] tmr_d;
  logic [15:0] width_q;
  logic [15:0] dead_q;
  logic [15:0] dead_cur;
  logic        hit;
  logic        accept;
  logic        drop;

  logic [WIN_W-1:0]      win_cnt;
  logic                  win_tc;
  logic [P_CNT_BITS-1:0] win_acc;
  logic [P_CNT_BITS-1:0] rate_nxt;

  assign hit = trig && enable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width_q <= P_WIDTH_RST;
      dead_q  <= P_DEAD_RST;
    end else begin
      if (width_wr) begin
        width_q <= width;
      end
      if (deadtime_wr) begin
        dead_q <= deadtime;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          accept  = 1'b1;
          state_d = HIGH;
          tmr_d   = load_val(width_q);
        end
      end
      HIGH: begin
        drop = hit;
        if (tmr_q == 16'd0) begin
          if (dead_cur != 16'd0) begin
            state_d = DEAD;
            tmr_d   = load_val(dead_cur);
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = 16'(tmr_q - 16'd1);
        end
      end
      DEAD: begin
        drop = hit;
        if (tmr_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          tmr_d = 16'(tmr_q - 16'd1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the next state so they leave the flops aligned
  // with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      dead_cur <= P_DEAD_RST;
      pulse_o  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pulse_o <= (state_d == HIGH);
      busy    <= (state_d != IDLE);
      if (accept) begin
        dead_cur <= dead_q;
      end
    end
  end

  sat_counter #(.W(P_CNT_BITS)) u_accept (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (accept),
    .cnt   (n_accept)
  );

  sat_counter #(.W(P_CNT_BITS)) u_drop (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (drop),
    .cnt   (n_drop)
  );

  sat_counter #(.W(P_CNT_BITS)) u_win_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr || win_tc),
    .inc   (accept),
    .cnt   (win_acc)
  );

  assign win_tc = (win_cnt == WIN_LAST);

  // The terminal cycle's own accept belongs to the closing window.
  always_comb begin
    rate_nxt = win_acc;
    if (accept && !(&win_acc)) begin
      rate_nxt = win_acc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (cnt_clr) begin
        win_cnt <= '0;
      end else if (win_tc) begin
        win_cnt    <= '0;
        rate       <= rate_nxt;
        rate_valid <= 1'b1;
      end else begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_shaper.sv
// Directed bench for pulse_shaper: timing, drops, config, rate
// window, reset and counter saturation.
module tb_pulse_shaper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic        enable;
  logic [15:0] width;
  logic        width_wr;
  logic [15:0] deadtime;
  logic        deadtime_wr;
  logic        cnt_clr;

  logic        pulse_o;
  logic        busy;
  logic [31:0] n_accept;
  logic [31:0] n_drop;
  logic [31:0] rate;
  logic        rate_valid;

  logic        s_pulse_o;
  logic        s_busy;
  logic [3:0]  s_n_accept;
  logic [3:0]  s_n_drop;
  logic [3:0]  s_rate;
  logic        s_rate_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pulse_shaper #(
    .P_CNT_BITS    (32),
    .P_RATE_WINDOW (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig        (trig),
    .enable      (enable),
    .width       (width),
    .width_wr    (width_wr),
    .deadtime    (deadtime),
    .deadtime_wr (deadtime_wr),
    .cnt_clr     (cnt_clr),
    .pulse_o     (pulse_o),
    .busy        (busy),
    .n_accept    (n_accept),
    .n_drop      (n_drop),
    .rate        (rate),
    .rate_valid  (rate_valid)
  );

  pulse_shaper #(
    .P_CNT_BITS    (4),
    .P_RATE_WINDOW (100)
  ) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig        (trig),
    .enable      (enable),
    .width       (width),
    .width_wr    (width_wr),
    .deadtime    (deadtime),
    .deadtime_wr (deadtime_wr),
    .cnt_clr     (cnt_clr),
    .pulse_o     (s_pulse_o),
    .busy        (s_busy),
    .n_accept    (s_n_accept),
    .n_drop      (s_n_drop),
    .rate        (s_rate),
    .rate_valid  (s_rate_valid)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic shot(
    input  bit          wr,
    input  logic [15:0] wv,
    output int          hl,
    output int          dl
  );
    trig = 1'b1;
    tick();
    trig = 1'b0;
    if (wr) begin
      width    = wv;
      width_wr = 1'b1;
    end
    hl = 0;
    dl = 0;
    while (pulse_o && hl < 64) begin
      hl++;
      tick();
      width_wr = 1'b0;
    end
    width_wr = 1'b0;
    while (busy && dl < 64) begin
      dl++;
      tick();
    end
  endtask

  logic [9:0]  pat1;
  logic [19:0] pat2;
  logic        any_hi;
  int          hl;
  int          dl;
  int          c0;

  initial begin
    rst_n       = 1'b0;
    trig        = 1'b0;
    enable      = 1'b0;
    width       = '0;
    width_wr    = 1'b0;
    deadtime    = '0;
    deadtime_wr = 1'b0;
    cnt_clr     = 1'b0;

    repeat (3) tick();
    check("rst_pulse", pulse_o, 0);
    check("rst_busy", busy, 0);
    check("rst_acc", n_accept, 0);
    check("rst_rate", rate, 0);
    check("rst_rv", rate_valid, 0);
    rst_n = 1'b1;
    tick();

    // default W=5, D=0 single trigger
    enable = 1'b1;
    trig   = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pat1[i] = pulse_o;
      tick();
    end
    check("w5_pattern", pat1, 10'b0000011111);
    check("w5_acc", n_accept, 1);
    check("w5_drop", n_drop, 0);

    // W=3 D=4, trigger every cycle
    width       = 16'd3;
    width_wr    = 1'b1;
    deadtime    = 16'd4;
    deadtime_wr = 1'b1;
    cnt_clr     = 1'b1;
    tick();
    width_wr    = 1'b0;
    deadtime_wr = 1'b0;
    cnt_clr     = 1'b0;
    trig        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      pat2[i] = pulse_o;
    end
    trig = 1'b0;
    check("burst_pattern", pat2, 20'h70707);
    check("burst_acc", n_accept, 3);
    check("burst_drop", n_drop, 17);
    repeat (10) tick();

    // mid-pulse width write applies to the next pulse
    shot(1'b1, 16'd10, hl, dl);
    check("wr_mid_len", hl, 3);
    check("wr_mid_dead", dl, 4);
    shot(1'b0, 16'd0, hl, dl);
    check("wr_next_len", hl, 10);
    width       = 16'd0;
    width_wr    = 1'b1;
    deadtime    = 16'd0;
    deadtime_wr = 1'b1;
    tick();
    width_wr    = 1'b0;
    deadtime_wr = 1'b0;
    shot(1'b0, 16'd0, hl, dl);
    check("w0_len", hl, 1);
    check("d0_dead", dl, 0);

    // disabled triggers are ignored
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    enable  = 1'b0;
    any_hi  = 1'b0;
    repeat (5) begin
      trig = 1'b1;
      tick();
      any_hi |= pulse_o;
      trig = 1'b0;
      tick();
      any_hi |= pulse_o;
    end
    enable = 1'b1;
    check("dis_pulse", any_hi, 0);
    check("dis_acc", n_accept, 0);
    check("dis_drop", n_drop, 0);

    // rate window with clear colliding with an accept
    width    = 16'd1;
    width_wr = 1'b1;
    tick();
    width_wr = 1'b0;
    cnt_clr  = 1'b1;
    trig     = 1'b1;
    tick();
    c0      = cyc;
    cnt_clr = 1'b0;
    trig    = 1'b0;
    check("clr_acc", n_accept, 0);
    check("clr_fsm", pulse_o, 1);
    repeat (7) begin
      tick();
      trig = 1'b1;
      tick();
      trig = 1'b0;
    end
    while (!rate_valid && (cyc - c0) < 300) tick();
    check("rate_cycle", cyc - c0, 100);
    check("rate_val", rate, 7);
    check("rate_acc", n_accept, 7);
    tick();
    check("rate_strobe", rate_valid, 0);
    check("rate_hold", rate, 7);

    // reset during HIGH
    width    = 16'd10;
    width_wr = 1'b1;
    tick();
    width_wr = 1'b0;
    trig     = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    check("pre_rst_hi", pulse_o, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_pulse", pulse_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_acc", n_accept, 0);
    check("mid_rst_drop", n_drop, 0);
    check("mid_rst_rate", rate, 0);
    rst_n = 1'b1;
    tick();
    shot(1'b0, 16'd0, hl, dl);
    check("rst_width", hl, 5);

    // saturation on the narrow instance
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    trig    = 1'b1;
    repeat (20) tick();
    check("sat_drop_a", s_n_drop, 4'hF);
    check("wide_drop_a", n_drop, 16);
    check("sat_acc_a", s_n_accept, 4);
    repeat (10) tick();
    trig = 1'b0;
    check("sat_drop_b", s_n_drop, 4'hF);
    check("wide_drop_b", n_drop, 25);
    check("wide_acc_b", n_accept, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
